// File: rtl/stark_branch_rsq.sv
// Multi-entry branch reservation queue: operands wake up off the tag buses, the oldest
// fully-ready entry issues to the branch unit, and entries on squashed checkpoints drop out.
module stark_branch_rsq #(
  parameter int DEPTH  = 4,
  parameter int NARGS  = 3,
  parameter int NPORTS = 16,
  parameter int WID    = 64,
  parameter int PRW    = 8,
  parameter int RIW    = 5,
  parameter int NCP    = 16,
  parameter int INFOW  = 32,
  parameter int CP_LSB = 0,
  parameter logic [INFOW-1:0] NOP_INFO = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_v,
  input  logic                      rndxv,
  input  logic [RIW-1:0]            rndx,
  input  logic [NARGS*PRW-1:0]      disp_prs,
  input  logic [INFOW-1:0]          disp_info,
  output logic                      full_o,
  input  logic [NPORTS*PRW-1:0]     prn,
  input  logic [NPORTS-1:0]         prnv,
  input  logic [NPORTS*WID-1:0]     rfo,
  input  logic [NPORTS-1:0]         rfo_tag,
  input  logic                      bu_ready,
  output logic                      iss_v,
  output logic [RIW-1:0]            iss_id,
  output logic [NARGS*WID-1:0]      iss_args,
  output logic [NARGS-1:0]          iss_tags,
  output logic [INFOW-1:0]          iss_info,
  input  logic                      kill_v,
  input  logic [NCP-1:0]            kill_cpmask,
  output logic [$clog2(DEPTH):0]    occ_o
);

  localparam int CPW = $clog2(NCP);
  localparam int OCW = $clog2(DEPTH) + 1;
  localparam int IXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic           hit;
    logic           tag;
    logic [WID-1:0] val;
  } wk_t;

  // Highest-numbered matching port wins because later ports overwrite earlier hits.
  function automatic wk_t wk_lookup(input logic [PRW-1:0] preg,
                                    input logic [NPORTS*PRW-1:0] tags,
                                    input logic [NPORTS-1:0] tagv,
                                    input logic [NPORTS*WID-1:0] vals,
                                    input logic [NPORTS-1:0] vtag);
    wk_t r;
    r = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (tagv[p] && (tags[p*PRW +: PRW] == preg)) begin
        r.hit = 1'b1;
        r.tag = vtag[p];
        r.val = vals[p*WID +: WID];
      end
    end
    return r;
  endfunction

  function automatic logic [OCW-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [OCW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {{(OCW-1){1'b0}}, v[i]};
    return c;
  endfunction

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0]                 age_q [DEPTH];
  logic [DEPTH-1:0]                 age_d [DEPTH];
  logic [RIW-1:0]                   rid_q [DEPTH];
  logic [RIW-1:0]                   rid_d [DEPTH];
  logic [INFOW-1:0]                 info_q [DEPTH];
  logic [INFOW-1:0]                 info_d [DEPTH];
  logic [NARGS-1:0][PRW-1:0]        prs_q [DEPTH];
  logic [NARGS-1:0][PRW-1:0]        prs_d [DEPTH];
  logic [NARGS-1:0][WID-1:0]        val_q [DEPTH];
  logic [NARGS-1:0][WID-1:0]        val_d [DEPTH];
  logic [NARGS-1:0]                 opv_q [DEPTH];
  logic [NARGS-1:0]                 opv_d [DEPTH];
  logic [NARGS-1:0]                 tagb_q [DEPTH];
  logic [NARGS-1:0]                 tagb_d [DEPTH];

  logic [DEPTH-1:0]                 ready_s, sel_oh_s, kill_hit_s, freed_s;
  logic [DEPTH-1:0]                 older_s [DEPTH];
  logic [IXW-1:0]                   sel_idx_s, free_idx_s;
  logic                             issue_s, disp_ok_s;

  logic                             iss_v_q, full_q;
  logic [RIW-1:0]                   iss_id_q;
  logic [NARGS*WID-1:0]             iss_args_q;
  logic [NARGS-1:0]                 iss_tags_q;
  logic [INFOW-1:0]                 iss_info_q;
  logic [OCW-1:0]                   occ_q;

  // Readiness only looks at registered operand state, so a wakeup costs one cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i]    = valid_q[i] & (&opv_q[i]);
      kill_hit_s[i] = kill_v & kill_cpmask[info_q[i][CP_LSB +: CPW]];
      for (int j = 0; j < DEPTH; j++) older_s[i][j] = age_q[j][i];
    end
  end

  // Oldest-ready select, issue decision and lowest free slot.
  always_comb begin
    sel_idx_s  = '0;
    free_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) sel_oh_s[i] = ready_s[i] & ~(|(ready_s & older_s[i]));
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sel_oh_s[i]) sel_idx_s = IXW'(i);
      else sel_idx_s = sel_idx_s;
      if (!valid_q[i]) free_idx_s = IXW'(i);
      else free_idx_s = free_idx_s;
    end
    issue_s   = bu_ready & (|sel_oh_s) & ~kill_hit_s[sel_idx_s];
    freed_s   = kill_hit_s | (sel_oh_s & {DEPTH{issue_s}});
    disp_ok_s = disp_v & rndxv & ~full_q & ~(kill_v & kill_cpmask[disp_info[CP_LSB +: CPW]]);
  end

  // Next-state: retire freed entries, wake waiting operands, write the dispatched op.
  always_comb begin
    wk_t wk;
    logic [PRW-1:0] p;
    wk = '0;
    p  = '0;
    valid_d = valid_q & ~freed_s;
    for (int i = 0; i < DEPTH; i++) begin
      rid_d[i]  = rid_q[i];
      info_d[i] = info_q[i];
      prs_d[i]  = prs_q[i];
      val_d[i]  = val_q[i];
      opv_d[i]  = opv_q[i];
      tagb_d[i] = tagb_q[i];
      for (int j = 0; j < DEPTH; j++) age_d[i][j] = age_q[i][j] & ~freed_s[i] & ~freed_s[j];
      for (int a = 0; a < NARGS; a++) begin
        wk = wk_lookup(prs_q[i][a], prn, prnv, rfo, rfo_tag);
        if (!opv_q[i][a] && wk.hit) begin
          opv_d[i][a]  = 1'b1;
          val_d[i][a]  = wk.val;
          tagb_d[i][a] = wk.tag;
        end else begin
          opv_d[i][a]  = opv_d[i][a];
        end
      end
    end
    if (disp_ok_s) begin
      valid_d[free_idx_s] = 1'b1;
      rid_d[free_idx_s]   = rndx;
      info_d[free_idx_s]  = disp_info;
      age_d[free_idx_s]   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (i != int'(free_idx_s)) age_d[i][free_idx_s] = valid_d[i];
        else age_d[i][free_idx_s] = 1'b0;
      end
      for (int a = 0; a < NARGS; a++) begin
        p  = disp_prs[a*PRW +: PRW];
        wk = wk_lookup(p, prn, prnv, rfo, rfo_tag);
        prs_d[free_idx_s][a] = p;
        if (p == '0) begin
          opv_d[free_idx_s][a]  = 1'b1;
          val_d[free_idx_s][a]  = '0;
          tagb_d[free_idx_s][a] = 1'b0;
        end else if (wk.hit) begin
          opv_d[free_idx_s][a]  = 1'b1;
          val_d[free_idx_s][a]  = wk.val;
          tagb_d[free_idx_s][a] = wk.tag;
        end else begin
          opv_d[free_idx_s][a]  = 1'b0;
          val_d[free_idx_s][a]  = '0;
          tagb_d[free_idx_s][a] = 1'b0;
        end
      end
    end else begin
      valid_d = valid_d;
    end
  end

  // Control state: valid bits, age matrix, occupancy and issue outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      iss_v_q    <= 1'b0;
      iss_id_q   <= '0;
      iss_args_q <= '0;
      iss_tags_q <= '0;
      iss_info_q <= NOP_INFO;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
      occ_q   <= popcnt(valid_d);
      full_q  <= (popcnt(valid_d) == OCW'(DEPTH));
      iss_v_q <= issue_s;
      if (issue_s) begin
        iss_id_q   <= rid_q[sel_idx_s];
        iss_args_q <= val_q[sel_idx_s];
        iss_tags_q <= tagb_q[sel_idx_s];
        iss_info_q <= info_q[sel_idx_s];
      end else begin
        iss_id_q   <= iss_id_q;
      end
    end
  end

  // Entry payload; meaningless while the valid bit is clear, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      rid_q[i]  <= rid_d[i];
      info_q[i] <= info_d[i];
      prs_q[i]  <= prs_d[i];
      val_q[i]  <= val_d[i];
      opv_q[i]  <= opv_d[i];
      tagb_q[i] <= tagb_d[i];
    end
  end

  assign full_o   = full_q;
  assign occ_o    = occ_q;
  assign iss_v    = iss_v_q;
  assign iss_id   = iss_id_q;
  assign iss_args = iss_args_q;
  assign iss_tags = iss_tags_q;
  assign iss_info = iss_info_q;

endmodule

// File: tb/tb_stark_branch_rsq.sv
// Bench for stark_branch_rsq: directed scenarios plus random traffic, all checked against
// an age-ordered list model of the queue.
module tb_stark_branch_rsq;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_v, rndxv;
  logic [4:0]    rndx;
  logic [23:0]   disp_prs;
  logic [31:0]   disp_info;
  logic          full_o;
  logic [127:0]  prn;
  logic [15:0]   prnv;
  logic [1023:0] rfo;
  logic [15:0]   rfo_tag;
  logic          bu_ready;
  logic          iss_v;
  logic [4:0]    iss_id;
  logic [191:0]  iss_args;
  logic [2:0]    iss_tags;
  logic [31:0]   iss_info;
  logic          kill_v;
  logic [15:0]   kill_cpmask;
  logic [2:0]    occ_o;

  stark_branch_rsq dut (
    .clk(clk), .rst(rst), .disp_v(disp_v), .rndxv(rndxv), .rndx(rndx),
    .disp_prs(disp_prs), .disp_info(disp_info), .full_o(full_o),
    .prn(prn), .prnv(prnv), .rfo(rfo), .rfo_tag(rfo_tag), .bu_ready(bu_ready),
    .iss_v(iss_v), .iss_id(iss_id), .iss_args(iss_args), .iss_tags(iss_tags),
    .iss_info(iss_info), .kill_v(kill_v), .kill_cpmask(kill_cpmask), .occ_o(occ_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]        rid;
    logic [31:0]       info;
    logic [2:0][7:0]   prs;
    logic [2:0][63:0]  val;
    logic [2:0]        tg;
    logic [2:0]        ov;
  } ent_t;

  ent_t         mq[$];
  logic         exp_v;
  logic [4:0]   exp_id;
  logic [191:0] exp_args;
  logic [2:0]   exp_tags;
  logic [31:0]  exp_info;
  int           checks = 0;
  int           failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_killed(input logic [31:0] info);
    return kill_v && kill_cpmask[info[3:0]];
  endfunction

  task automatic wlook(input logic [7:0] p, output bit hit, output logic [63:0] v, output logic t);
    hit = 0; v = '0; t = 1'b0;
    for (int k = 0; k < 16; k++)
      if (prnv[k] && prn[k*8 +: 8] == p) begin hit = 1; v = rfo[k*64 +: 64]; t = rfo_tag[k]; end
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic step();
    int n0, cand;
    bit hit;
    logic [63:0] v;
    logic t;
    ent_t e;
    if (rst) begin
      mq.delete();
      exp_v = 1'b0; exp_id = '0; exp_args = '0; exp_tags = '0; exp_info = '0;
    end else begin
      n0 = mq.size();
      cand = -1;
      for (int i = 0; i < mq.size(); i++) if (&mq[i].ov) begin cand = i; break; end
      exp_v = 1'b0;
      if (bu_ready && cand >= 0 && !is_killed(mq[cand].info)) begin
        exp_v = 1'b1; exp_id = mq[cand].rid; exp_args = mq[cand].val;
        exp_tags = mq[cand].tg; exp_info = mq[cand].info;
        mq.delete(cand);
      end
      for (int i = mq.size() - 1; i >= 0; i--) if (is_killed(mq[i].info)) mq.delete(i);
      for (int i = 0; i < mq.size(); i++)
        for (int a = 0; a < 3; a++)
          if (!mq[i].ov[a]) begin
            wlook(mq[i].prs[a], hit, v, t);
            if (hit) begin mq[i].ov[a] = 1'b1; mq[i].val[a] = v; mq[i].tg[a] = t; end
          end
      if (disp_v && rndxv && n0 < 4 && !is_killed(disp_info)) begin
        e = '0; e.rid = rndx; e.info = disp_info;
        for (int a = 0; a < 3; a++) begin
          e.prs[a] = disp_prs[a*8 +: 8];
          if (e.prs[a] == 8'd0) e.ov[a] = 1'b1;
          else begin
            wlook(e.prs[a], hit, v, t);
            if (hit) begin e.ov[a] = 1'b1; e.val[a] = v; e.tg[a] = t; end
          end
        end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("iss_v", 256'(iss_v), 256'(exp_v));
    chk("iss_id", 256'(iss_id), 256'(exp_id));
    chk("iss_args", 256'(iss_args), 256'(exp_args));
    chk("iss_tags", 256'(iss_tags), 256'(exp_tags));
    chk("iss_info", 256'(iss_info), 256'(exp_info));
    chk("occ_o", 256'(occ_o), 256'(mq.size()));
    chk("full_o", 256'(full_o), 256'(mq.size() == 4));
  endtask

  task automatic idle();
    disp_v = 1'b0; rndxv = 1'b1; rndx = '0; disp_prs = '0; disp_info = '0;
    prn = '0; prnv = '0; rfo = '0; rfo_tag = '0; kill_v = 1'b0; kill_cpmask = '0;
  endtask

  task automatic disp(input logic [4:0] id, input logic [23:0] prs, input logic [3:0] cp);
    disp_v = 1'b1; rndx = id; disp_prs = prs; disp_info = {28'h0000abc, cp};
  endtask

  task automatic wake(input int p, input logic [7:0] tg, input logic [63:0] v);
    prnv[p] = 1'b1; prn[p*8 +: 8] = tg; rfo[p*64 +: 64] = v; rfo_tag[p] = 1'b1;
  endtask

  task automatic drain();
    idle(); bu_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    idle(); bu_ready = 1'b0; rst = 1'b1;
    step(); step();
    chk("reset_occ", 256'(occ_o), 256'(0));
    chk("reset_iss_v", 256'(iss_v), 256'(0));
    rst = 1'b0;

    // 1: zero-operand op issues two edges after dispatch
    bu_ready = 1'b1; disp(5'd3, 24'h0, 4'd1); step();
    idle(); step();
    chk("t1_iss_v", 256'(iss_v), 256'(1));
    chk("t1_iss_id", 256'(iss_id), 256'(3));
    chk("t1_args", 256'(iss_args), 256'(0));
    drain();

    // 2: younger ready op overtakes an older waiting one
    disp(5'd1, 24'h00000c, 4'd1); step();
    disp(5'd2, 24'h0, 4'd1); step();
    idle(); wake(5, 8'd12, 64'h55); step();
    chk("t2_b_first", 256'(iss_id), 256'(2));
    idle(); step();
    chk("t2_a_iss_v", 256'(iss_v), 256'(1));
    chk("t2_a_id", 256'(iss_id), 256'(1));
    chk("t2_a_arg0", 256'(iss_args[63:0]), 256'(64'h55));
    drain();

    // 3: fill, drop overflow dispatch, then free one slot
    for (int i = 0; i < 4; i++) begin disp(5'(10 + i), 24'h000014, 4'd1); step(); end
    chk("t3_full", 256'(full_o), 256'(1));
    chk("t3_occ", 256'(occ_o), 256'(4));
    disp(5'd20, 24'h0, 4'd1); step();
    chk("t3_drop_occ", 256'(occ_o), 256'(4));
    idle(); wake(0, 8'd20, 64'h1234); step();
    idle(); step();
    chk("t3_not_full", 256'(full_o), 256'(0));
    drain();

    // 4: kill one of two ready entries in the issue cycle
    bu_ready = 1'b0;
    disp(5'd7, 24'h0, 4'd5); step();
    disp(5'd8, 24'h0, 4'd2); step();
    idle(); step();
    chk("t4_occ_before", 256'(occ_o), 256'(2));
    bu_ready = 1'b1; kill_v = 1'b1; kill_cpmask = 16'h0004; step();
    chk("t4_iss_id", 256'(iss_id), 256'(7));
    chk("t4_occ_after", 256'(occ_o), 256'(0));
    drain();

    // 5: branch unit busy holds a ready entry
    bu_ready = 1'b0; disp(5'd9, 24'h0, 4'd3); step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_v", 256'(iss_v), 256'(0));
    end
    chk("t5_retained", 256'(occ_o), 256'(1));
    bu_ready = 1'b1; step();
    chk("t5_iss_id", 256'(iss_id), 256'(9));
    step();
    chk("t5_single", 256'(iss_v), 256'(0));
    drain();

    // 6: same-cycle capture at dispatch
    disp(5'd10, 24'h090000, 4'd1); wake(0, 8'd9, 64'hAA); step();
    idle(); step();
    chk("t6_iss_v", 256'(iss_v), 256'(1));
    chk("t6_arg2", 256'(iss_args[191:128]), 256'(64'hAA));
    drain();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      disp_v = ($urandom_range(0, 1) == 0);
      rndxv = ($urandom_range(0, 7) != 0);
      rndx = 5'($urandom);
      for (int a = 0; a < 3; a++)
        disp_prs[a*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 15));
      disp_info = $urandom;
      for (int p = 0; p < 16; p++) begin
        prnv[p] = ($urandom_range(0, 7) == 0);
        prn[p*8 +: 8] = 8'($urandom_range(0, 15));
        rfo[p*64 +: 64] = {$urandom, $urandom};
        rfo_tag[p] = 1'($urandom);
      end
      bu_ready = ($urandom_range(0, 3) != 0);
      kill_v = ($urandom_range(0, 15) == 0);
      kill_cpmask = 16'($urandom);
      step();
    end
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
